// File: rtl/fsqrt_issue_if.sv
// Handshake bundle between FPU dispatch, the fsqrt pipeline and writeback.
// The issue stage is the slave; the surrounding logic (or a bench) is the master.
`timescale 1ns/1ps
interface fsqrt_issue_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      sq_x;
    logic [31:0]      sq_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport slave (
        input  in_valid, in_x, in_tag, sq_y, out_ready,
        output in_ready, sq_x, out_valid, out_y, out_tag, busy
    );

    modport master (
        output in_valid, in_x, in_tag, sq_y, out_ready,
        input  in_ready, sq_x, out_valid, out_y, out_tag, busy
    );
endinterface

// File: rtl/fsqrt_issue.sv
// Issue/retire wrapper for the non-stallable fsqrt pipe: tags ride a shadow
// pipe, results land in a small FIFO, and credits stop the FIFO from overflowing.
`timescale 1ns/1ps
module fsqrt_issue #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    fsqrt_issue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                w_fire;
    logic                w_pop;
    logic                w_push;
    logic [LATENCY-1:0]  w_vld_in;
    logic [TAG_W-1:0]    w_tag_in [LATENCY];

    logic [LATENCY-1:0]  r_vld;
    logic [TAG_W-1:0]    r_tag    [LATENCY];
    logic [31:0]         r_mem_y  [DEPTH];
    logic [TAG_W-1:0]    r_mem_tag[DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_occ;

    // occ counts in-flight plus queued ops, so a fired op always has a FIFO slot.
    assign bus.in_ready  = !rst && (r_occ < CNT_W'(DEPTH));
    assign w_fire        = bus.in_valid && bus.in_ready;
    assign bus.sq_x      = bus.in_x;
    assign w_push        = r_vld[LATENCY-1];
    assign bus.out_valid = (r_count != '0);
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign bus.out_y     = r_mem_y[r_rd_ptr];
    assign bus.out_tag   = r_mem_tag[r_rd_ptr];
    assign bus.busy      = (r_occ != '0);

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_track
            if (gi == 0) begin : g_head
                assign w_vld_in[gi] = w_fire;
                assign w_tag_in[gi] = bus.in_tag;
            end else begin : g_body
                assign w_vld_in[gi] = r_vld[gi-1];
                assign w_tag_in[gi] = r_tag[gi-1];
            end
        end
    endgenerate

    // Only the valid bits need clearing: stale tags are never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_in;
        end
        r_tag <= w_tag_in;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_y[r_wr_ptr]   <= bus.sq_y;
            r_mem_tag[r_wr_ptr] <= r_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_occ <= r_occ + CNT_W'(w_fire) - CNT_W'(w_pop);
        end
    end
endmodule

// File: tb/tb_fsqrt_issue.sv
// Directed and random bench for fsqrt_issue with a behavioural fsqrt pipe and
// a scoreboard of expected {result, tag} filled at fire time.
`timescale 1ns/1ps
module tb_fsqrt_issue;
    localparam int LATENCY = 4;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsqrt_issue_if #(.TAG_W(TAG_W)) bus ();

    fsqrt_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   fires     = 0;
    int   pops      = 0;
    int   overflows = 0;
    logic last_fire = 1'b0;
    exp_t sb[$];

    // Reference square root for positive normal singles; the double result
    // rounded to nearest is exact because sqrt never lands on a tie.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        int  ue;
        int  mant;
        real v;
        real s;
        if ($isunknown(x)) return 32'hxxxxxxxx;
        if (x[31] || x[30:23] == 8'd0 || x[30:23] == 8'hFF) return 32'h7FC00000;
        ue = int'(x[30:23]) - 127;
        v  = 1.0 + real'(x[22:0]) / 8388608.0;
        if (ue % 2 != 0) begin
            v  = v * 2.0;
            ue = ue - 1;
        end
        s    = $sqrt(v);
        mant = $rtoi((s - 1.0) * 8388608.0 + 0.5);
        return {1'b0, 8'(ue / 2 + 127), mant[22:0]};
    endfunction

    logic [31:0] sq_pipe [LATENCY];
    always @(posedge clk) begin
        sq_pipe[0] <= ref_sqrt(bus.sq_x);
        for (int k = 1; k < LATENCY; k++) sq_pipe[k] <= sq_pipe[k-1];
    end
    assign bus.sq_y = sq_pipe[LATENCY-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Scoreboard update for the current cycle, then step to just after the edge.
    task automatic adv();
        exp_t e;
        last_fire = 1'b0;
        if (dut.w_push && dut.r_count == DEPTH && !dut.w_pop) overflows++;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_tag", 32'(bus.out_tag), 32'(e.tag));
                    chk("sb_y", bus.out_y, e.y);
                    pops++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.y   = ref_sqrt(bus.in_x);
                e.tag = bus.in_tag;
                sb.push_back(e);
                fires++;
                last_fire = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        at_neg();
        adv();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    logic             exp_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [TAG_W-1:0] nxt_tag;
    int               f0;
    int               p0;
    int               n;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = 32'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        at_neg(); chk("rst_in_ready", 32'(bus.in_ready), 32'd0); adv();
        cycle();
        rst = 1'b0;
        at_neg();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        adv();

        // Single op: sqrt(4.0) = 2.0, visible at c+LATENCY+1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'h40800000;
        bus.in_tag    = 5'd3;
        at_neg(); chk("t1_fire", 32'(bus.in_ready), 32'd1); adv();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            at_neg(); chk("t1_early_valid", 32'(bus.out_valid), 32'd0); adv();
        end
        at_neg();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_y", bus.out_y, 32'h40000000);
        chk("t1_tag", 32'(bus.out_tag), 32'd3);
        adv();
        at_neg();
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk("t1_out_valid_clr", 32'(bus.out_valid), 32'd0);
        adv();

        // Credit stall with in_valid held high
        bus.in_valid = 1'b1;
        nxt_tag = '0;
        for (int c = 0; nxt_tag < 8 && c < 100; c++) begin
            bus.in_x   = {1'b0, 8'd127, 23'($urandom)};
            bus.in_tag = nxt_tag;
            at_neg();
            if (c < 7) chk("t2_in_ready", 32'(bus.in_ready), 32'(exp_rdy[c]));
            if (c == 5) begin
                chk("t2_c5_valid", 32'(bus.out_valid), 32'd1);
                chk("t2_c5_tag", 32'(bus.out_tag), 32'd0);
            end
            adv();
            if (last_fire) nxt_tag++;
        end
        bus.in_valid = 1'b0;
        drain("t2_drain");

        // Backpressure: only DEPTH ops admitted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        nxt_tag = '0;
        f0 = fires;
        for (int c = 0; c < 8; c++) begin
            bus.in_x   = {1'b0, 8'd127, 23'($urandom)};
            bus.in_tag = nxt_tag;
            at_neg(); adv();
            if (last_fire) nxt_tag++;
        end
        bus.in_valid = 1'b0;
        chk("t3_accepted", 32'(fires - f0), 32'd4);
        at_neg();
        chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_hold_tag", 32'(bus.out_tag), 32'd0);
        chk("t3_hold_ready", 32'(bus.in_ready), 32'd0);
        adv();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("t3_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_tag", 32'(bus.out_tag), 32'(k));
            chk("t3_in_ready", 32'(bus.in_ready), (k == 0) ? 32'd0 : 32'd1);
            adv();
        end
        at_neg();
        chk("t3_empty", 32'(bus.out_valid), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        adv();

        // Simultaneous push and pop with three entries queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.in_x   = {1'b0, 8'd127, 23'($urandom)};
            bus.in_tag = 5'(10 + c);
            at_neg(); chk("t4_fire", 32'(bus.in_ready), 32'd1); adv();
        end
        bus.in_valid = 1'b0;
        for (int c = 4; c < 7; c++) cycle();
        bus.out_ready = 1'b1;
        at_neg(); chk("t4_head_a", 32'(bus.out_tag), 32'd10); adv();
        bus.out_ready = 1'b0;
        at_neg();
        chk("t4_valid_b", 32'(bus.out_valid), 32'd1);
        chk("t4_head_b", 32'(bus.out_tag), 32'd11);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
        adv();
        bus.out_ready = 1'b1;
        p0 = pops;
        drain("t4_drain");
        chk("t4_remaining", 32'(pops - p0), 32'd3);

        // Reset while two ops are in flight
        bus.in_valid = 1'b1;
        bus.in_x = 32'h41100000; bus.in_tag = 5'd1; cycle();
        bus.in_x = 32'h41800000; bus.in_tag = 5'd2; cycle();
        rst = 1'b1;
        bus.in_tag = 5'd3;
        at_neg(); chk("t5_rst_ready", 32'(bus.in_ready), 32'd0); adv();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        at_neg();
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        adv();
        for (int c = 0; c < 8; c++) begin
            at_neg(); chk("t5_discard", 32'(bus.out_valid), 32'd0); adv();
        end

        // Random traffic on [1,2) operands
        f0 = fires;
        n = 0;
        nxt_tag = '0;
        while (fires - f0 < 1024 && n < 20000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_x      = {1'b0, 8'd127, 23'($urandom)};
            bus.in_tag    = nxt_tag;
            cycle();
            if (last_fire) nxt_tag++;
            n++;
        end
        chk("t6_timeout", 32'(n < 20000), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("t6_drain");

        chk("overflow", 32'(overflows), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
